// File: rtl/vga_monitor_if.sv
// vga_monitor_if: sync and colour lines from a vga timing block to its monitor
interface vga_monitor_if;
    logic hs;
    logic vs;
    logic r;
    logic g;
    logic b;
    modport master (output hs, vs, r, g, b);
    modport slave (input hs, vs, r, g, b);
endinterface

// File: rtl/vga_monitor.sv
// vga_monitor: measures hs/vs timing, compares it with the expected timing and reports lock and sticky errors.
// Define VGA_MONITOR_PIXCNT_EN to add the per-frame lit-pixel counter output pix_lit.
module vga_monitor #(
    parameter int H_TOTAL  = 1600,
    parameter int H_SYNC   = 192,
    parameter int V_TOTAL  = 525,
    parameter int V_SYNC   = 2,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic          clock,
    input  logic          reset_n,
    vga_monitor_if.slave  vga,
    input  logic          clr,
    output logic [11:0]   h_period,
    output logic [11:0]   h_width,
    output logic [10:0]   v_lines,
    output logic [10:0]   v_width,
    output logic [15:0]   frame_cnt,
    output logic          locked,
    output logic          err_h,
    output logic          err_v
`ifdef VGA_MONITOR_PIXCNT_EN
    ,
    output logic [19:0]   pix_lit
`endif
);
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t state, state_n;
    logic good, good_n;
    logic hs_q, hs_d, vs_q, vs_d, clr_q;
    logic hs_act, vs_act, hs_lead, hs_trail, vs_lead, vs_trail;
    logic h_mis, v_mis, h_seen;
    logic [11:0] hcnt, wcnt;
    logic [10:0] lcnt, vwcnt;

    assign hs_act   = hs_q == SYNC_POL;
    assign vs_act   = vs_q == SYNC_POL;
    assign hs_lead  = hs_act && (hs_d != SYNC_POL);
    assign hs_trail = !hs_act && (hs_d == SYNC_POL);
    assign vs_lead  = vs_act && (vs_d != SYNC_POL);
    assign vs_trail = !vs_act && (vs_d == SYNC_POL);
    assign h_mis = (state != SEARCH) && h_seen &&
                   ((hs_lead && hcnt != 12'(H_TOTAL)) || (hs_trail && wcnt != 12'(H_SYNC)));
    assign v_mis = (state != SEARCH) &&
                   ((vs_lead && lcnt != 11'(V_TOTAL)) || (vs_trail && vwcnt != 11'(V_SYNC)));
    assign locked = state == LOCKED;

    // Register inputs once, then delay the syncs again so edges are seen between the two stages
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            {hs_q, hs_d, vs_q, vs_d} <= {4{~SYNC_POL}};
            clr_q <= 1'b0;
        end else begin
            {hs_q, vs_q, clr_q} <= {vga.hs, vga.vs, clr};
            {hs_d, vs_d} <= {hs_q, vs_q};
        end
    end

    // Saturating counters and the measurements latched from them at sync edges
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            {hcnt, wcnt, lcnt, vwcnt, h_seen} <= '0;
            {h_period, h_width, v_lines, v_width, frame_cnt, err_h, err_v} <= '0;
        end else begin
            hcnt  <= hs_lead ? 12'd1 : hcnt + {11'd0, ~&hcnt};
            wcnt  <= hs_lead ? 12'd1 : wcnt + {11'd0, hs_act & ~&wcnt};
            lcnt  <= vs_lead ? {10'd0, hs_lead} : lcnt + {10'd0, hs_lead & ~&lcnt};
            vwcnt <= vs_lead ? {10'd0, hs_lead} : vwcnt + {10'd0, hs_lead & vs_act & ~&vwcnt};
            h_seen <= h_seen | hs_lead;
            if (hs_lead) h_period <= hcnt;
            if (hs_trail) h_width <= wcnt;
            if (vs_lead) v_lines <= lcnt;
            if (vs_lead) frame_cnt <= frame_cnt + 16'd1;
            if (vs_trail) v_width <= vwcnt;
            err_h <= (err_h & ~clr_q) | h_mis;
            err_v <= (err_v & ~clr_q) | v_mis;
        end
    end

    // Lock state and clean-frame count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEARCH;
            good  <= 1'b0;
        end else begin
            state <= state_n;
            good  <= good_n;
        end
    end

    // Lock after two consecutive clean frames; any mismatch restarts the search
    always_comb begin
        state_n = state;
        good_n  = good;
        if (state == SEARCH) begin
            if (vs_lead) begin
                state_n = MEASURE;
                good_n  = 1'b0;
            end
        end else if (h_mis || v_mis) begin
            state_n = SEARCH;
        end else if (vs_lead && state == MEASURE) begin
            good_n = 1'b1;
            if (good) state_n = LOCKED;
        end
    end

`ifdef VGA_MONITOR_PIXCNT_EN
    logic lit_q;
    logic [19:0] pcnt;

    // Count lit clocks per frame and publish the total at each vs leading edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lit_q   <= 1'b0;
            pcnt    <= '0;
            pix_lit <= '0;
        end else begin
            lit_q <= vga.r | vga.g | vga.b;
            pcnt  <= vs_lead ? {19'd0, lit_q} : pcnt + {19'd0, lit_q & ~&pcnt};
            if (vs_lead) pix_lit <= pcnt;
        end
    end
`endif
endmodule
